// File: rtl/apb_wait_completer_pkg.sv
// Shared APB definitions: transfer state type, default bus geometry and the
// address-check helpers used by the completer.
package apb_wait_completer_pkg;

    localparam int APB_ADDR_WIDTH = 16;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int APB_ALIGNBITS  = $clog2(APB_STRB_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } apb_state_e;

    // Address is passed zero-extended to 32 bits so one helper serves any PADDR width.
    function automatic logic addr_misaligned(input logic [31:0] addr, input int align_bits);
        logic [31:0] mask;
        mask = (32'd1 << align_bits) - 32'd1;
        return (addr & mask) != 32'd0;
    endfunction

    function automatic logic [2:0] region_prot(input logic priv);
        return priv ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/apb_byte_mem.sv
// Word storage with per-byte-lane write enables and a registered read port
// that can be forced to zero.
module apb_byte_mem
    import apb_wait_completer_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int STRB_W     = DATA_WIDTH / 8
)(
    input  logic                  clk_sys,
    input  logic                  rst_b,
    input  logic                  wr_en,
    input  logic [STRB_W-1:0]     wr_strb,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents survive reset on purpose; only the read register is cleared.
    always_ff @(posedge clk_sys) begin
        for (int n = 0; n < STRB_W; n++) begin
            if (wr_en && wr_strb[n]) begin
                mem[wr_idx][8*n +: 8] <= wr_data[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/apb_wait_completer.sv
// APB4 completer: byte-strobed word storage with a fixed wait-state count and
// legality checks (alignment, range, protection, strobe) reported on PSLVERR.
//
// state  | meaning
// IDLE   | waiting for a setup cycle
// SETUP  | transfer captured, counting down wait states
// ACCESS | PREADY high, OK response; a write commits at the end of this cycle
// ERROR  | PREADY high with PSLVERR, PRDATA zero, nothing written
module apb_wait_completer
    import apb_wait_completer_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int PROT_CHECK  = 1
)(
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int ALIGN_W = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);

    apb_state_e            state;
    logic [3:0]            wait_cnt;
    logic                  wr_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;

    logic                  setup_hit;
    logic                  abort;
    logic                  last_wait;
    logic [ADDR_WIDTH-1:0] addr_low;
    logic                  mis_err;
    logic                  range_err;
    logic                  prot_err;
    logic                  strb_err;
    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;

    logic                  enter_ok;
    logic                  enter_err;
    logic                  rd_is_read;
    logic [IDX_W-1:0]      rd_idx;
    logic                  mem_wr_en;
    logic                  mem_rd_en;

    assign setup_hit = PSEL & ~PENABLE;
    assign abort     = ~PSEL | ~PENABLE;
    assign last_wait = (wait_cnt == 4'd1);

    // The privileged bit is dropped before the range check so both windows alias.
    assign addr_low  = {1'b0, PADDR[ADDR_WIDTH-2:0]};
    assign mis_err   = addr_misaligned(32'(PADDR), ALIGN_W);
    assign range_err = (addr_low >> (ALIGN_W + IDX_W)) != '0;
    assign prot_err  = (PROT_CHECK != 0) && (PPROT != region_prot(PADDR[ADDR_WIDTH-1]));
    assign strb_err  = ~PWRITE && (PSTRB != '0);
    assign setup_err = mis_err | range_err | prot_err | strb_err;
    assign setup_idx = PADDR[ALIGN_W +: IDX_W];

    // Completion is decided one edge early so PREADY, PSLVERR and PRDATA all
    // come straight out of flops in the completion cycle.
    always_comb begin
        enter_ok   = 1'b0;
        enter_err  = 1'b0;
        rd_is_read = ~wr_q;
        rd_idx     = idx_q;
        case (state)
            IDLE: begin
                if (setup_hit && (WAIT_CYCLES == 0)) begin
                    enter_ok   = ~setup_err;
                    enter_err  = setup_err;
                    rd_is_read = ~PWRITE;
                    rd_idx     = setup_idx;
                end
            end
            SETUP: begin
                if (!abort && last_wait) begin
                    enter_ok  = ~err_q;
                    enter_err = err_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_wr_en = (state == ACCESS) && wr_q;
    assign mem_rd_en = enter_ok && rd_is_read;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
        end else begin
            PREADY  <= enter_ok | enter_err;
            PSLVERR <= enter_err;
            case (state)
                IDLE: begin
                    if (setup_hit) begin
                        wr_q    <= PWRITE;
                        err_q   <= setup_err;
                        idx_q   <= setup_idx;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        if (WAIT_CYCLES == 0) begin
                            state <= setup_err ? ERROR : ACCESS;
                        end else begin
                            state    <= SETUP;
                            wait_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                SETUP: begin
                    if (abort) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (last_wait) begin
                        state    <= err_q ? ERROR : ACCESS;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: state <= IDLE;
                ERROR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    apb_byte_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .STRB_W     (STRB_W)
    ) u_mem (
        .clk_sys (PCLK),
        .rst_b   (PRESETn),
        .wr_en   (mem_wr_en),
        .wr_strb (strb_q),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_en   (mem_rd_en),
        .rd_clr  (enter_err),
        .rd_idx  (rd_idx),
        .rd_data (PRDATA)
    );

endmodule

// File: tb/tb_apb_wait_completer.sv
// Bench for apb_wait_completer: three instances (zero-wait, three-wait, no
// protection check) driven one transfer at a time against a word/byte model.
module tb_apb_wait_completer;
    import apb_wait_completer_pkg::*;

    localparam int NDUT = 3;

    logic                      PCLK = 1'b0;
    logic                      PRESETn = 1'b1;
    logic [NDUT-1:0]           psel = '0;
    logic                      PENABLE = 1'b0;
    logic                      PWRITE = 1'b0;
    logic [APB_ADDR_WIDTH-1:0] PADDR = '0;
    logic [APB_DATA_WIDTH-1:0] PWDATA = '0;
    logic [APB_STRB_WIDTH-1:0] PSTRB = '0;
    logic [2:0]                PPROT = '0;

    logic                      pready  [NDUT];
    logic                      pslverr [NDUT];
    logic [APB_DATA_WIDTH-1:0] prdata  [NDUT];

    int checks = 0;
    int failures = 0;

    int wait_of [NDUT] = '{0, 3, 0};
    bit prot_of [NDUT] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] ref_mem [NDUT][256];

    always #5 PCLK = ~PCLK;

    apb_wait_completer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0), .PROT_CHECK(1)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb_wait_completer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(3), .PROT_CHECK(1)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    apb_wait_completer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0), .PROT_CHECK(0)) dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Error rule in plain arithmetic: 4-byte words, 256 words, bit 15 = privileged window.
    function automatic bit exp_err(input int d, input bit wr, input logic [15:0] addr,
                                   input logic [3:0] strb, input logic [2:0] prot);
        int a;
        bit e;
        a = int'(addr);
        e = (a % 4) != 0;
        if (((a % 32768) / 1024) != 0) e = 1'b1;
        if (prot_of[d] && (prot != ((a >= 32768) ? 3'd7 : 3'd0))) e = 1'b1;
        if (!wr && strb != 4'd0) e = 1'b1;
        return e;
    endfunction

    task automatic idle();
        @(posedge PCLK); #1;
        psel = '0;
        PENABLE = 1'b0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input string tag);
        bit e;
        int idx;
        int k;
        logic [31:0] expd;
        e = exp_err(d, wr, addr, strb, prot);
        idx = (int'(addr) % 1024) / 4;
        @(posedge PCLK); #1;
        psel = '0;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PWRITE = wr;
        PADDR = addr;
        PWDATA = data;
        PSTRB = strb;
        PPROT = prot;
        @(negedge PCLK);
        check({tag, "/t0_ready"}, 32'(pready[d]), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        k = 0;
        @(negedge PCLK);
        while (pready[d] !== 1'b1 && k < 20) begin
            k++;
            @(negedge PCLK);
        end
        check({tag, "/latency"}, 32'(k), 32'(wait_of[d]));
        check({tag, "/pslverr"}, 32'(pslverr[d]), 32'(e));
        if (wr && !e) begin
            for (int n = 0; n < 4; n++)
                if (strb[n]) ref_mem[d][idx][8*n +: 8] = data[8*n +: 8];
        end
        if (!wr || e) begin
            expd = e ? 32'd0 : ref_mem[d][idx];
            check({tag, "/prdata"}, prdata[d], expd);
        end
    endtask

    initial begin
        bit seen;
        int d;
        int idx;
        bit wr;
        logic [15:0] addr;
        logic [3:0] strb;
        logic [2:0] prot;

        #2 PRESETn = 1'b0;
        #2;
        for (int i = 0; i < NDUT; i++) begin
            check("reset_ready", 32'(pready[i]), 32'd0);
            check("reset_slverr", 32'(pslverr[i]), 32'd0);
            check("reset_prdata", prdata[i], 32'd0);
        end
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        for (int i = 0; i < NDUT; i++)
            for (int j = 0; j < 16; j++)
                xfer(i, 1'b1, 16'(j * 4), $urandom, 4'hF, 3'd0, "fill");
        idle();

        // Zero-wait basic write/read and partial strobe merge
        xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'd0, "p1_wr");
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p1_rd");
        check("p1_const", prdata[0], 32'hDEADBEEF);
        xfer(0, 1'b1, 16'h0010, 32'h11223344, 4'b0101, 3'd0, "p2_wr");
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p2_rd");
        check("p2_const", prdata[0], 32'hDE22BE44);
        xfer(0, 1'b1, 16'h0010, 32'h99999999, 4'h0, 3'd0, "nop_wr");
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "nop_rd");
        idle();

        // Three wait states, back-to-back
        xfer(1, 1'b1, 16'h0010, 32'hA5A5F00F, 4'hF, 3'd0, "p3_wr");
        xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p3_rd");
        xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p3_b2b");
        check("p3_const", prdata[1], 32'hA5A5F00F);
        idle();

        // Error cases leave memory untouched
        xfer(0, 1'b1, 16'h0012, 32'h01010101, 4'hF, 3'd0, "p4_misal");
        xfer(0, 1'b1, 16'h0400, 32'h02020202, 4'hF, 3'd0, "p4_range");
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h1, 3'd0, "p4_strb");
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p4_rd");
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, 3'd0, "p4_rd0");
        xfer(1, 1'b1, 16'h0013, 32'h03030303, 4'hF, 3'd0, "p4_misal_w3");
        idle();

        // Protection window and aliasing
        xfer(0, 1'b1, 16'h8010, 32'hCAFEF00D, 4'hF, 3'd0, "p5_badprot");
        xfer(0, 1'b1, 16'h8010, 32'hCAFEF00D, 4'hF, 3'd7, "p5_priv_wr");
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p5_alias_rd");
        check("p5_const", prdata[0], 32'hCAFEF00D);
        xfer(2, 1'b1, 16'h8010, 32'h0BADCAFE, 4'hF, 3'd0, "p5_noprot_wr");
        xfer(2, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd5, "p5_noprot_rd");
        check("p5_noprot_const", prdata[2], 32'h0BADCAFE);

        // Abort: PSEL dropped in the second wait cycle
        @(posedge PCLK); #1;
        psel = 3'b010; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 16'h0010; PWDATA = 32'h55555555; PSTRB = 4'hF; PPROT = 3'd0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 psel = '0; PENABLE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (pready[1] === 1'b1) seen = 1'b1;
        end
        check("p6_abort_ready", 32'(seen), 32'd0);
        xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p6_abort_rd");

        // Reset during the wait phase of a write
        @(posedge PCLK); #1;
        psel = 3'b010; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 16'h0010; PWDATA = 32'h12345678; PSTRB = 4'hF; PPROT = 3'd0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PRESETn = 1'b0;
        #1;
        check("p6_rst_ready", 32'(pready[1]), 32'd0);
        check("p6_rst_slverr", 32'(pslverr[1]), 32'd0);
        check("p6_rst_prdata", prdata[1], 32'd0);
        psel = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, "p6_rst_rd");
        idle();

        // Randomized mix across all three instances
        for (int t = 0; t < 150; t++) begin
            d = $urandom_range(0, NDUT - 1);
            wr = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            addr = 16'(idx * 4);
            prot = 3'd0;
            strb = wr ? 4'($urandom) : 4'd0;
            case ($urandom_range(0, 7))
                0, 1, 2: ;
                3: begin addr[15] = 1'b1; prot = 3'd7; end
                4: addr = addr + 16'($urandom_range(1, 3));
                5: addr = addr + 16'(1024 * $urandom_range(1, 31));
                6: prot = 3'($urandom);
                default: if (!wr) strb = 4'($urandom);
            endcase
            xfer(d, wr, addr, $urandom, strb, prot, "rand");
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
